// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared encodings and address check for the data memory arbiter
package data_mem_pkg;

    localparam int unsigned DEFAULT_MEM_BYTES = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_t;

    // 33-bit sum so an address near 2^32 cannot wrap back into range.
    function automatic logic addr_legal(input logic [31:0] addr, input logic [32:0] last_byte);
        logic [32:0] top_byte;
        top_byte = {1'b0, addr} + 33'd3;
        return (addr[1:0] == 2'b00) && (top_byte <= last_byte);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin decision, combinational
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        if (req == 2'b11) begin
            grant = ~last;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - CPU/DMA arbiter in front of a single-port data RAM
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES  = DEFAULT_MEM_BYTES,
    parameter logic        RESET_LAST = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ack,
    output logic        dma_err,
    output logic [31:0] dma_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata
);

    localparam logic [32:0] LAST_BYTE = 33'(MEM_BYTES) - 33'd1;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    port_t       sel_q, sel_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        arb_grant;
    logic        arb_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_legal;

    rr_arb2 u_rr_arb2 (
        .req   ({dma_req, cpu_req}),
        .last  (last_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    assign req_we    = arb_grant ? dma_we    : cpu_we;
    assign req_addr  = arb_grant ? dma_addr  : cpu_addr;
    assign req_wdata = arb_grant ? dma_wdata : cpu_wdata;
    assign req_legal = addr_legal(req_addr, LAST_BYTE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= RESET_LAST;
            sel_q   <= PORT_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decode from registered state only, so reset clears them at once.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        sel_d     = sel_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        cpu_ack   = 1'b0;
        cpu_err   = 1'b0;
        cpu_rdata = '0;
        dma_ack   = 1'b0;
        dma_err   = 1'b0;
        dma_rdata = '0;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    sel_d   = port_t'(arb_grant);
                    last_d  = arb_grant;
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = ~req_legal;
                    rdata_d = '0;
                    state_d = req_legal ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_write = we_q;
                mem_read  = ~we_q;
                rdata_d   = we_q ? 32'h0 : mem_rdata;
                state_d   = RESP;
            end
            RESP: begin
                if (sel_q == PORT_CPU) begin
                    cpu_ack   = 1'b1;
                    cpu_err   = err_q;
                    cpu_rdata = rdata_q;
                end else begin
                    dma_ack   = 1'b1;
                    dma_err   = err_q;
                    dma_rdata = rdata_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
